// File: rtl/frequency_mem_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : frequency_mem_reg
// Brief   : Parallel-load holding register for the NCO frequency word.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module frequency_mem_reg #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] r_word;

  // One flop per bit with a load/recirculate mux on its D input.
  generate
    for (genvar k = 0; k < WIDTH; k++) begin : g_bits
      logic w_d;
      logic r_bit;

      assign w_d = LOAD ? IN[k] : r_bit;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_bit <= 1'b0;
        end else begin
          r_bit <= w_d;
        end
      end

      assign r_word[k] = r_bit;
    end
  endgenerate

  assign OUT = r_word;

endmodule
`default_nettype wire

// File: tb/tb_frequency_mem_reg.sv
`default_nettype none
// Directed bench for frequency_mem_reg; expected words queued at drive time, popped at check.
module tb_frequency_mem_reg;

  localparam int WIDTH = 20;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_w;
  logic             load;
  logic [WIDTH-1:0] out_w;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model;
  logic [WIDTH-1:0] exp_q[$];
  string            tag_q[$];

  frequency_mem_reg #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .IN   (in_w),
    .LOAD (load),
    .OUT  (out_w)
  );

  task automatic push_exp(input string tag, input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [WIDTH-1:0] exp;
    string            tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (out_w === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, out_w, exp);
    end
  endtask

  // One rising edge, sampled 1 time unit after it; inputs change only while clk is low.
  task automatic step(input string tag);
    logic [WIDTH-1:0] exp;
    exp   = reset ? '0 : (load ? in_w : model);
    model = exp;
    push_exp(tag, exp);
    #5 clk = 1'b1;
    #1 compare();
    #4 clk = 1'b0;
  endtask

  task automatic load_word(input string tag, input logic [WIDTH-1:0] v);
    load = 1'b1;
    in_w = v;
    step(tag);
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    load  = 1'b0;
    in_w  = '0;
    model = '0;

    // Asynchronous reset with no clock running.
    #3 reset = 1'b1;
    #1 push_exp("reset_async", '0);
    compare();
    #5 reset = 1'b0;
    for (int i = 0; i < 3; i++) step("reset_release_hold");

    // Single load followed by loading zero.
    load_word("single_load", 20'd79021);
    load_word("single_load_zero", 20'd0);

    // No combinational path from IN/LOAD to OUT.
    load_word("preload", 20'h0AAAA);
    in_w = 20'h05555;
    #2 push_exp("no_comb_path", 20'h0AAAA);
    compare();

    // Tracking: LOAD held high.
    for (int i = 0; i <= 498; i++) load_word("track", WIDTH'(i));
    push_exp("track_final", 20'd498);
    compare();

    // Hold: IN changes ignored while LOAD is low.
    load_word("hold_preload", 20'd0);
    load = 1'b0;
    for (int i = 0; i <= 498; i++) begin
      in_w = WIDTH'(i);
      step("hold");
    end

    // Width extremes.
    load_word("max_word", 20'hFFFFF);
    load_word("edge_bits", 20'h80001);
    load_word("zero_word", 20'h00000);

    // Reset mid-operation.
    load_word("mid_preload", 20'd79021);
    load = 1'b1;
    in_w = 20'h12345;
    #2 reset = 1'b1;
    #1 push_exp("mid_reset_async", '0);
    compare();
    model = '0;
    step("mid_reset_over_edge");
    reset = 1'b0;
    step("mid_reset_release_load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
